// File: rtl/pipelined_mul_unit_if.sv
// Handshake and result bus between the EX-stage issue logic and pipelined_mul_unit.
// slave = multiplier side, master = issue/writeback side.
interface pipelined_mul_unit_if #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 5
) ();
  logic                    in_valid;
  logic                    in_ready;
  logic [1:0]              in_op;
  logic                    in_word;
  logic [XLEN-1:0]         in_a;
  logic [XLEN-1:0]         in_b;
  logic [TAG_W-1:0]        in_rd;
  logic                    flush;
  logic                    out_valid;
  logic                    out_ready;
  logic [XLEN-1:0]         out_result;
  logic [TAG_W-1:0]        out_rd;
  logic [(1<<TAG_W)-1:0]   pend_mask;
  logic                    busy;

  modport slave (
    input  in_valid, in_op, in_word, in_a, in_b, in_rd, flush, out_ready,
    output in_ready, out_valid, out_result, out_rd, pend_mask, busy
  );

  modport master (
    output in_valid, in_op, in_word, in_a, in_b, in_rd, flush, out_ready,
    input  in_ready, out_valid, out_result, out_rd, pend_mask, busy
  );
endinterface

// File: rtl/pipelined_mul_unit.sv
// Fully pipelined RV64M multiplier (MUL/MULH/MULHSU/MULHU) with rd tag and pending-rd mask.
// Optional MULW support is compiled in when MULW_EN is defined.
module pipelined_mul_unit #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned STAGES = 3,
  parameter int unsigned TAG_W  = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  pipelined_mul_unit_if.slave  bus
);

  localparam int unsigned H  = XLEN / 2;
  localparam int unsigned PW = XLEN + 2;
  localparam int unsigned NR = 1 << TAG_W;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } op_e;

  logic hold, adv, accept;
  assign hold         = bus.out_valid && !bus.out_ready;
  assign adv          = !hold;
  assign bus.in_ready = reset && !hold && !bus.flush;
  assign accept       = bus.in_valid && bus.in_ready;

  // Operand decode: both operands widened to XLEN+1 so one signed multiply covers all ops
  op_e             in_op;
  logic            sign_a, sign_b, word_d;
  logic [XLEN:0]   ax_d, bx_d;
  assign in_op = op_e'(bus.in_op);

  always_comb begin
    word_d = 1'b0;
    sign_a = (in_op == OP_MULH) || (in_op == OP_MULHSU);
    sign_b = (in_op == OP_MULH);
    ax_d   = {sign_a & bus.in_a[XLEN-1], bus.in_a};
    bx_d   = {sign_b & bus.in_b[XLEN-1], bus.in_b};
`ifdef MULW_EN
    if (bus.in_word) begin
      word_d = 1'b1;
      ax_d   = {{(XLEN-31){bus.in_a[31]}}, bus.in_a[31:0]};
      bx_d   = {{(XLEN-31){bus.in_b[31]}}, bus.in_b[31:0]};
    end
`endif
  end

`ifndef MULW_EN
  logic unused_in_word;
  assign unused_in_word = bus.in_word;
`endif

  logic [STAGES:1]   vld_q, vld_d;
  logic [TAG_W-1:0]  rd_q [1:STAGES];
  logic [XLEN:0]     ax1_q, bx1_q;
  op_e               op1_q, op2_q;
  logic              word1_q, word2_q;
  logic [XLEN-1:0]   ll2_q;
  logic [PW-1:0]     lh2_q, hl2_q, hh2_q;

  // Stage 1 -> 2: four partial products over a split at bit H (low halves unsigned)
  logic [H-1:0]          al, bl;
  logic [H:0]            ah, bh;
  logic [XLEN-1:0]       ll_d;
  logic signed [PW-1:0]  lh_d, hl_d, hh_d;

  always_comb begin
    al   = ax1_q[H-1:0];
    bl   = bx1_q[H-1:0];
    ah   = ax1_q[XLEN:H];
    bh   = bx1_q[XLEN:H];
    ll_d = {{H{1'b0}}, al} * {{H{1'b0}}, bl};
    lh_d = $signed({{(PW-H){1'b0}}, al}) * $signed({{(PW-H-1){bh[H]}}, bh});
    hl_d = $signed({{(PW-H-1){ah[H]}}, ah}) * $signed({{(PW-H){1'b0}}, bl});
    hh_d = $signed({{(PW-H-1){ah[H]}}, ah}) * $signed({{(PW-H-1){bh[H]}}, bh});
  end

  // Stage 2: recombine partial products mod 2^(2*XLEN) and pick the requested half
  logic [PW:0]        mid;
  logic [2*XLEN-1:0]  prod;
  logic [XLEN-1:0]    res2;

  always_comb begin
    mid  = {lh2_q[PW-1], lh2_q} + {hl2_q[PW-1], hl2_q};
    prod = {{XLEN{1'b0}}, ll2_q}
         + ({{(2*XLEN-PW-1){mid[PW]}}, mid} << H)
         + {hh2_q[XLEN-1:0], {XLEN{1'b0}}};
    if (word2_q)
      res2 = {{(XLEN-32){prod[31]}}, prod[31:0]};
    else if (op2_q == OP_MUL)
      res2 = prod[XLEN-1:0];
    else
      res2 = prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    vld_d = vld_q;
    if (bus.flush)
      vld_d = '0;
    else if (adv)
      vld_d = {vld_q[STAGES-1:1], accept};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q   <= '0;
      ax1_q   <= '0;
      bx1_q   <= '0;
      op1_q   <= OP_MUL;
      word1_q <= 1'b0;
      op2_q   <= OP_MUL;
      word2_q <= 1'b0;
      ll2_q   <= '0;
      lh2_q   <= '0;
      hl2_q   <= '0;
      hh2_q   <= '0;
      for (int unsigned i = 1; i <= STAGES; i++) rd_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      if (adv) begin
        ax1_q   <= ax_d;
        bx1_q   <= bx_d;
        op1_q   <= in_op;
        word1_q <= word_d;
        op2_q   <= op1_q;
        word2_q <= word1_q;
        ll2_q   <= ll_d;
        lh2_q   <= lh_d;
        hl2_q   <= hl_d;
        hh2_q   <= hh_d;
        rd_q[1] <= bus.in_rd;
        for (int unsigned i = 2; i <= STAGES; i++) rd_q[i] <= rd_q[i-1];
      end
    end
  end

  // Stages beyond 2 only delay the finished result to reach the configured latency
  if (STAGES > 2) begin : g_res
    logic [XLEN-1:0] res_q [3:STAGES];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int unsigned i = 3; i <= STAGES; i++) res_q[i] <= '0;
      end else if (adv) begin
        res_q[3] <= res2;
        for (int unsigned i = 4; i <= STAGES; i++) res_q[i] <= res_q[i-1];
      end
    end

    assign bus.out_result = res_q[STAGES];
  end else begin : g_nores
    assign bus.out_result = res2;
  end

  logic [NR-1:0] pend;

  always_comb begin
    pend = '0;
    for (int unsigned i = 1; i <= STAGES; i++)
      if (vld_q[i]) pend[rd_q[i]] = 1'b1;
    pend[0] = 1'b0;
  end

  assign bus.out_valid = vld_q[STAGES];
  assign bus.out_rd    = rd_q[STAGES];
  assign bus.pend_mask = pend;
  assign bus.busy      = |vld_q;

endmodule

// File: tb/tb_pipelined_mul_unit.sv
// Directed + random bench for pipelined_mul_unit; results checked against a plain 2*XLEN-product model.
// Honours MULW_EN the same way as the design.
module tb_pipelined_mul_unit;
  localparam int unsigned XLEN   = 64;
  localparam int unsigned STAGES = 3;
  localparam int unsigned TAG_W  = 5;

  typedef struct packed {
    logic [1:0]       op;
    logic             word;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [TAG_W-1:0] rd;
  } req_t;

  logic clk = 1'b0;
  logic reset;
  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [XLEN-1:0]  exp_res_q [$];
  logic [TAG_W-1:0] exp_rd_q  [$];

  pipelined_mul_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  pipelined_mul_unit #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] model(req_t r);
    logic signed [2*XLEN+1:0] pa, pb, p;
`ifdef MULW_EN
    if (r.word) begin
      pa = {{(XLEN+34){r.a[31]}}, r.a[31:0]};
      pb = {{(XLEN+34){r.b[31]}}, r.b[31:0]};
      p  = pa * pb;
      return {{(XLEN-32){p[31]}}, p[31:0]};
    end
`endif
    pa = (r.op == 2'b01 || r.op == 2'b10) ? {{(XLEN+2){r.a[XLEN-1]}}, r.a} : {{(XLEN+2){1'b0}}, r.a};
    pb = (r.op == 2'b01) ? {{(XLEN+2){r.b[XLEN-1]}}, r.b} : {{(XLEN+2){1'b0}}, r.b};
    p  = pa * pb;
    return (r.op == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return '1;
      1:       return {1'b1, {(XLEN-1){1'b0}}};
      2:       return '0;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.op   = 2'($urandom_range(0, 3));
    r.word = ($urandom_range(0, 7) == 0);
    r.a    = rand_operand();
    r.b    = rand_operand();
    r.rd   = TAG_W'($urandom_range(0, (1 << TAG_W) - 1));
    return r;
  endfunction

  task automatic drive(input req_t r);
    bus.in_valid = 1'b1;
    bus.in_op    = r.op;
    bus.in_word  = r.word;
    bus.in_a     = r.a;
    bus.in_b     = r.b;
    bus.in_rd    = r.rd;
  endtask

  // One clock: scoreboard bookkeeping at the falling edge, then return just after the rising edge
  task automatic tick();
    req_t r;
    @(negedge clk);
    if (bus.out_valid && bus.out_ready) begin
      chk("retire_expected", 64'(exp_res_q.size() != 0), 64'd1);
      if (exp_res_q.size() != 0) begin
        chk("sb_result", bus.out_result, exp_res_q.pop_front());
        chk("sb_rd", 64'(bus.out_rd), 64'(exp_rd_q.pop_front()));
      end
    end
    if (bus.flush) begin
      exp_res_q.delete();
      exp_rd_q.delete();
    end
    if (bus.in_valid && bus.in_ready) begin
      r.op = bus.in_op; r.word = bus.in_word; r.a = bus.in_a; r.b = bus.in_b; r.rd = bus.in_rd;
      exp_res_q.push_back(model(r));
      exp_rd_q.push_back(r.rd);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input string tag, input req_t r, input logic [XLEN-1:0] expv);
    int n = 0;
    drive(r);
    do begin
      tick();
      n++;
      bus.in_valid = 1'b0;
    end while (!bus.out_valid && n < 20);
    chk({tag, "_latency"}, 64'(n), 64'(STAGES));
    chk({tag, "_result"}, bus.out_result, expv);
    chk({tag, "_rd"}, 64'(bus.out_rd), 64'(r.rd));
    tick();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_res_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_queue_empty"}, 64'(exp_res_q.size()), 64'd0);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    req_t r;
    logic [XLEN-1:0] snap;

    reset = 1'b0;
    bus.in_valid = 1'b0; bus.in_op = 2'b00; bus.in_word = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.in_rd = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_result", bus.out_result, 64'd0);
    chk("rst_out_rd", 64'(bus.out_rd), 64'd0);
    chk("rst_pend", 64'(bus.pend_mask), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    reset = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Directed arithmetic
    r = '{op: 2'b00, word: 1'b0, a: 64'd7, b: -64'sd3, rd: 5'd3};
    run_one("mul_sign", r, 64'hFFFF_FFFF_FFFF_FFEB);
    r = '{op: 2'b01, word: 1'b0, a: '1, b: '1, rd: 5'd4};
    run_one("mulh", r, 64'h0);
    r = '{op: 2'b11, word: 1'b0, a: '1, b: 64'd2, rd: 5'd6};
    run_one("mulhu", r, 64'h1);
    r = '{op: 2'b10, word: 1'b0, a: '1, b: 64'd2, rd: 5'd0};
    run_one("mulhsu", r, 64'hFFFF_FFFF_FFFF_FFFF);

    // Random back-to-back stream with occasional backpressure
    for (int i = 0; i < 60; i++) begin
      drive(rand_req());
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
      chk("pend_bit0", 64'(bus.pend_mask[0]), 64'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drain("random");

    // Backpressure: five ops, then four stalled cycles
    for (int i = 0; i < 5; i++) begin
      drive(rand_req());
      tick();
    end
    drive(rand_req());
    bus.out_ready = 1'b0;
    #1;
    chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
    snap = bus.out_result;
    for (int i = 0; i < 4; i++) begin
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_stable", bus.out_result, snap);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    chk("bp_queue_depth", 64'(exp_res_q.size()), 64'd3);
    drain("bp");

    // Flush with rd=5 and rd=9 in flight
    r = rand_req(); r.rd = 5'd5; drive(r); tick();
    r = rand_req(); r.rd = 5'd9; drive(r); tick();
    r = rand_req(); r.rd = 5'd12; drive(r);
    bus.flush = 1'b1;
    #1;
    chk("flush_pend_set", 64'(bus.pend_mask), 64'h0000_0220);
    chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("flush_pend_clear", 64'(bus.pend_mask), 64'd0);
    chk("flush_busy", 64'(bus.busy), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("flush_no_retire", 64'(bus.out_valid), 64'd0);
    end

    // Asynchronous reset with two ops in flight
    drive(rand_req()); tick();
    drive(rand_req()); tick();
    bus.in_valid = 1'b0;
    reset = 1'b0;
    #1;
    exp_res_q.delete();
    exp_rd_q.delete();
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_out_result", bus.out_result, 64'd0);
    chk("mid_rst_out_rd", 64'(bus.out_rd), 64'd0);
    chk("mid_rst_pend", 64'(bus.pend_mask), 64'd0);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_no_retire", 64'(bus.out_valid), 64'd0);
    end

    // Word multiply request
`ifdef MULW_EN
    r = '{op: 2'b11, word: 1'b1, a: 64'h7FFF_FFFF, b: 64'd2, rd: 5'd7};
    run_one("mulw", r, 64'hFFFF_FFFF_FFFF_FFFE);
`else
    r = '{op: 2'b00, word: 1'b1, a: 64'h7FFF_FFFF, b: 64'd2, rd: 5'd7};
    run_one("mulw_ignored", r, 64'h0000_0000_FFFF_FFFE);
`endif
    drain("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
